// File: rtl/tlb_xlate_pipe.sv
// Registered N-port TLB output stage: selects the physical address/MAT from DIRECT, DMW or TLB
// translation, raises the translation exception, and presents one valid/ready stage per port.
module tlb_xlate_pipe #(
    parameter int NPORT = 2,
    parameter int PALEN = 32,
    parameter int CNTW  = 16
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        flush,
    input  logic [1:0]                  ad_mode,
    input  logic [1:0]                  cur_plv,
    input  logic [NPORT-1:0]            in_valid,
    output logic [NPORT-1:0]            in_ready,
    input  logic [NPORT*32-1:0]         in_vaddr,
    input  logic [NPORT*2-1:0]          in_acc,
    input  logic [NPORT-1:0]            in_dmw_hit,
    input  logic [NPORT*PALEN-1:0]      in_dmw_paddr,
    input  logic [NPORT*2-1:0]          in_dmw_mat,
    input  logic [NPORT-1:0]            in_tlb_found,
    input  logic [NPORT*(PALEN-12)-1:0] in_tlb_pfn,
    input  logic [NPORT*6-1:0]          in_tlb_ps,
    input  logic [NPORT*2-1:0]          in_tlb_mat,
    input  logic [NPORT-1:0]            in_tlb_v,
    input  logic [NPORT-1:0]            in_tlb_d,
    input  logic [NPORT*2-1:0]          in_tlb_plv,
    output logic [NPORT-1:0]            out_valid,
    input  logic [NPORT-1:0]            out_ready,
    output logic [NPORT*PALEN-1:0]      out_paddr,
    output logic [NPORT*2-1:0]          out_mat,
    output logic [NPORT*3-1:0]          out_exc,
    output logic [NPORT*CNTW-1:0]       miss_cnt
);

    localparam int PFNW = PALEN - 12;

    localparam logic [2:0] EXC_NONE = 3'd0;
    localparam logic [2:0] EXC_TLBR = 3'd1;
    localparam logic [2:0] EXC_PIF  = 3'd2;
    localparam logic [2:0] EXC_PIL  = 3'd3;
    localparam logic [2:0] EXC_PIS  = 3'd4;
    localparam logic [2:0] EXC_PPI  = 3'd5;
    localparam logic [2:0] EXC_PME  = 3'd6;
    localparam logic [2:0] EXC_ADE  = 3'd7;

    localparam logic [1:0] MODE_DIRECT = 2'b01;
    localparam logic [1:0] MODE_MAP    = 2'b10;
    localparam logic [1:0] ACC_FETCH   = 2'd0;
    localparam logic [1:0] ACC_STORE   = 2'd2;

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] cnt);
        return (&cnt) ? cnt : cnt + CNTW'(1);
    endfunction

    // Result packs {exc, mat, paddr}; any exception forces paddr and mat to zero.
    function automatic logic [PALEN+4:0] translate(
        input logic [1:0]       mode,
        input logic [1:0]       plv_cur,
        input logic [31:0]      va,
        input logic [1:0]       acc,
        input logic             dmw_hit,
        input logic [PALEN-1:0] dmw_pa,
        input logic [1:0]       dmw_mat,
        input logic             found,
        input logic [PFNW-1:0]  pfn,
        input logic [5:0]       ps,
        input logic [1:0]       tlb_mat,
        input logic             v,
        input logic             d,
        input logic [1:0]       tlb_plv
    );
        logic [PALEN-1:0] pa;
        logic [1:0]       mt;
        logic [2:0]       exc;
        pa  = '0;
        mt  = '0;
        exc = EXC_NONE;
        if (mode == MODE_DIRECT) begin
            pa = va[PALEN-1:0];
        end else if (mode != MODE_MAP) begin
            exc = EXC_ADE;
        end else if (dmw_hit) begin
            pa = dmw_pa;
            mt = dmw_mat;
        end else if (!found || (ps != 6'd12 && ps != 6'd22)) begin
            exc = EXC_TLBR;
        end else if (!v) begin
            exc = (acc == ACC_FETCH) ? EXC_PIF : (acc == ACC_STORE) ? EXC_PIS : EXC_PIL;
        end else if (plv_cur > tlb_plv) begin
            exc = EXC_PPI;
        end else if (acc == ACC_STORE && !d) begin
            exc = EXC_PME;
        end else begin
            mt = tlb_mat;
            pa = (ps == 6'd12) ? {pfn, va[11:0]} : {pfn[PFNW-1:10], va[21:0]};
        end
        return {exc, mt, pa};
    endfunction

    for (genvar p = 0; p < NPORT; p++) begin : g_port
        logic [PALEN+4:0] xlate_p0;
        logic             fire_p0;
        logic             vld_p1;
        logic [PALEN-1:0] paddr_p1;
        logic [1:0]       mat_p1;
        logic [2:0]       exc_p1;
        logic [CNTW-1:0]  miss_p1;

        assign xlate_p0 = translate(ad_mode, cur_plv, in_vaddr[p*32 +: 32], in_acc[p*2 +: 2],
                                    in_dmw_hit[p], in_dmw_paddr[p*PALEN +: PALEN],
                                    in_dmw_mat[p*2 +: 2], in_tlb_found[p],
                                    in_tlb_pfn[p*PFNW +: PFNW], in_tlb_ps[p*6 +: 6],
                                    in_tlb_mat[p*2 +: 2], in_tlb_v[p], in_tlb_d[p],
                                    in_tlb_plv[p*2 +: 2]);

        assign in_ready[p] = !vld_p1 || out_ready[p];
        assign fire_p0     = in_valid[p] && in_ready[p] && !flush;

        // p0 -> p1: result register; data only moves on a non-flushed accept
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                vld_p1   <= 1'b0;
                paddr_p1 <= '0;
                mat_p1   <= '0;
                exc_p1   <= '0;
                miss_p1  <= '0;
            end else begin
                if (flush)
                    vld_p1 <= 1'b0;
                else if (fire_p0)
                    vld_p1 <= 1'b1;
                else if (out_ready[p])
                    vld_p1 <= 1'b0;
                if (fire_p0) begin
                    {exc_p1, mat_p1, paddr_p1} <= xlate_p0;
                    if (xlate_p0[PALEN+4 -: 3] == EXC_TLBR)
                        miss_p1 <= sat_inc(miss_p1);
                end
            end
        end

        assign out_valid[p]              = vld_p1;
        assign out_paddr[p*PALEN +: PALEN] = paddr_p1;
        assign out_mat[p*2 +: 2]         = mat_p1;
        assign out_exc[p*3 +: 3]         = exc_p1;
        assign miss_cnt[p*CNTW +: CNTW]  = miss_p1;
    end

endmodule

// File: tb/tb_tlb_xlate_pipe.sv
// Self-checking bench for tlb_xlate_pipe: directed cases plus randomized traffic against a
// behavioural scoreboard; a CNTW=2 instance mirrors port 0 to exercise counter saturation.
module tb_tlb_xlate_pipe;

    localparam int NP   = 2;
    localparam int PA   = 32;
    localparam int CW   = 16;
    localparam int PFNW = PA - 12;

    logic              clk = 1'b0;
    logic              rstn;
    logic              flush;
    logic [1:0]        ad_mode;
    logic [1:0]        cur_plv;
    logic [NP-1:0]     in_valid;
    logic [NP-1:0]     in_ready;
    logic [NP*32-1:0]  in_vaddr;
    logic [NP*2-1:0]   in_acc;
    logic [NP-1:0]     in_dmw_hit;
    logic [NP*PA-1:0]  in_dmw_paddr;
    logic [NP*2-1:0]   in_dmw_mat;
    logic [NP-1:0]     in_tlb_found;
    logic [NP*PFNW-1:0] in_tlb_pfn;
    logic [NP*6-1:0]   in_tlb_ps;
    logic [NP*2-1:0]   in_tlb_mat;
    logic [NP-1:0]     in_tlb_v;
    logic [NP-1:0]     in_tlb_d;
    logic [NP*2-1:0]   in_tlb_plv;
    logic [NP-1:0]     out_valid;
    logic [NP-1:0]     out_ready;
    logic [NP*PA-1:0]  out_paddr;
    logic [NP*2-1:0]   out_mat;
    logic [NP*3-1:0]   out_exc;
    logic [NP*CW-1:0]  miss_cnt;

    logic              o2_valid;
    logic              i2_ready;
    logic [PA-1:0]     o2_paddr;
    logic [1:0]        o2_mat;
    logic [2:0]        o2_exc;
    logic [1:0]        o2_miss;

    logic [31:0]       t_vaddr    [NP];
    logic [1:0]        t_acc      [NP];
    logic              t_dmw_hit  [NP];
    logic [PA-1:0]     t_dmw_paddr[NP];
    logic [1:0]        t_dmw_mat  [NP];
    logic              t_found    [NP];
    logic [PFNW-1:0]   t_pfn      [NP];
    logic [5:0]        t_ps       [NP];
    logic [1:0]        t_mat      [NP];
    logic              t_v        [NP];
    logic              t_d        [NP];
    logic [1:0]        t_plv      [NP];

    int errors = 0;
    int checks = 0;

    always_comb begin
        for (int p = 0; p < NP; p++) begin
            in_vaddr[p*32 +: 32]     = t_vaddr[p];
            in_acc[p*2 +: 2]         = t_acc[p];
            in_dmw_hit[p]            = t_dmw_hit[p];
            in_dmw_paddr[p*PA +: PA] = t_dmw_paddr[p];
            in_dmw_mat[p*2 +: 2]     = t_dmw_mat[p];
            in_tlb_found[p]          = t_found[p];
            in_tlb_pfn[p*PFNW +: PFNW] = t_pfn[p];
            in_tlb_ps[p*6 +: 6]      = t_ps[p];
            in_tlb_mat[p*2 +: 2]     = t_mat[p];
            in_tlb_v[p]              = t_v[p];
            in_tlb_d[p]              = t_d[p];
            in_tlb_plv[p*2 +: 2]     = t_plv[p];
        end
    end

    tlb_xlate_pipe #(.NPORT(NP), .PALEN(PA), .CNTW(CW)) dut (
        .clk(clk), .rstn(rstn), .flush(flush), .ad_mode(ad_mode), .cur_plv(cur_plv),
        .in_valid(in_valid), .in_ready(in_ready), .in_vaddr(in_vaddr), .in_acc(in_acc),
        .in_dmw_hit(in_dmw_hit), .in_dmw_paddr(in_dmw_paddr), .in_dmw_mat(in_dmw_mat),
        .in_tlb_found(in_tlb_found), .in_tlb_pfn(in_tlb_pfn), .in_tlb_ps(in_tlb_ps),
        .in_tlb_mat(in_tlb_mat), .in_tlb_v(in_tlb_v), .in_tlb_d(in_tlb_d),
        .in_tlb_plv(in_tlb_plv), .out_valid(out_valid), .out_ready(out_ready),
        .out_paddr(out_paddr), .out_mat(out_mat), .out_exc(out_exc), .miss_cnt(miss_cnt)
    );

    tlb_xlate_pipe #(.NPORT(1), .PALEN(PA), .CNTW(2)) dut_sat (
        .clk(clk), .rstn(rstn), .flush(flush), .ad_mode(ad_mode), .cur_plv(cur_plv),
        .in_valid(in_valid[0:0]), .in_ready(i2_ready), .in_vaddr(in_vaddr[31:0]),
        .in_acc(in_acc[1:0]), .in_dmw_hit(in_dmw_hit[0:0]), .in_dmw_paddr(in_dmw_paddr[PA-1:0]),
        .in_dmw_mat(in_dmw_mat[1:0]), .in_tlb_found(in_tlb_found[0:0]),
        .in_tlb_pfn(in_tlb_pfn[PFNW-1:0]), .in_tlb_ps(in_tlb_ps[5:0]), .in_tlb_mat(in_tlb_mat[1:0]),
        .in_tlb_v(in_tlb_v[0:0]), .in_tlb_d(in_tlb_d[0:0]), .in_tlb_plv(in_tlb_plv[1:0]),
        .out_valid(o2_valid), .out_ready(out_ready[0:0]), .out_paddr(o2_paddr),
        .out_mat(o2_mat), .out_exc(o2_exc), .miss_cnt(o2_miss)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    // Reference translation, written directly from the exception-priority rules.
    function automatic logic [2:0] ref_exc(int p);
        if (ad_mode == 2'b01) return 3'd0;
        if (ad_mode != 2'b10) return 3'd7;
        if (t_dmw_hit[p]) return 3'd0;
        if (!t_found[p] || (t_ps[p] != 6'd12 && t_ps[p] != 6'd22)) return 3'd1;
        if (!t_v[p]) return (t_acc[p] == 2'd0) ? 3'd2 : (t_acc[p] == 2'd2) ? 3'd4 : 3'd3;
        if (cur_plv > t_plv[p]) return 3'd5;
        if (t_acc[p] == 2'd2 && !t_d[p]) return 3'd6;
        return 3'd0;
    endfunction

    function automatic logic [PA-1:0] ref_paddr(int p);
        longint va  = longint'(t_vaddr[p]);
        longint pfn = longint'(t_pfn[p]);
        if (ref_exc(p) != 3'd0) return '0;
        if (ad_mode == 2'b01) return t_vaddr[p];
        if (t_dmw_hit[p]) return t_dmw_paddr[p];
        if (t_ps[p] == 6'd12) return PA'(pfn * 4096 + va % 4096);
        return PA'((pfn / 1024) * 4194304 + va % 4194304);
    endfunction

    function automatic logic [1:0] ref_mat(int p);
        if (ref_exc(p) != 3'd0 || ad_mode == 2'b01) return 2'd0;
        return t_dmw_hit[p] ? t_dmw_mat[p] : t_mat[p];
    endfunction

    bit            m_valid[NP];
    logic [PA-1:0] m_paddr[NP];
    logic [1:0]    m_mat  [NP];
    logic [2:0]    m_exc  [NP];
    int            m_miss [NP];
    int            m_miss2;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int p = 0; p < NP; p++) begin
                m_valid[p] <= 1'b0;
                m_miss[p]  <= 0;
            end
            m_miss2 <= 0;
        end else begin
            for (int p = 0; p < NP; p++) begin
                if (flush) begin
                    m_valid[p] <= 1'b0;
                end else if (in_valid[p] && (!m_valid[p] || out_ready[p])) begin
                    m_valid[p] <= 1'b1;
                    m_paddr[p] <= ref_paddr(p);
                    m_mat[p]   <= ref_mat(p);
                    m_exc[p]   <= ref_exc(p);
                    if (ref_exc(p) == 3'd1) begin
                        if (m_miss[p] < 65535) m_miss[p] <= m_miss[p] + 1;
                        if (p == 0 && m_miss2 < 3) m_miss2 <= m_miss2 + 1;
                    end
                end else if (out_ready[p]) begin
                    m_valid[p] <= 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        flush     = 1'b0;
        ad_mode   = 2'b01;
        cur_plv   = 2'd0;
        in_valid  = '0;
        out_ready = '1;
        for (int p = 0; p < NP; p++) begin
            t_vaddr[p] = '0; t_acc[p] = '0; t_dmw_hit[p] = 1'b0; t_dmw_paddr[p] = '0;
            t_dmw_mat[p] = '0; t_found[p] = 1'b1; t_pfn[p] = '0; t_ps[p] = 6'd12;
            t_mat[p] = '0; t_v[p] = 1'b1; t_d[p] = 1'b1; t_plv[p] = 2'd3;
        end
    endtask

    task automatic set_tlb(int p, logic [31:0] va, logic [1:0] acc, logic [PFNW-1:0] pfn,
                           logic [5:0] ps, logic v, logic d, logic [1:0] plv, logic [1:0] mat);
        t_vaddr[p] = va; t_acc[p] = acc; t_dmw_hit[p] = 1'b0; t_found[p] = 1'b1;
        t_pfn[p] = pfn; t_ps[p] = ps; t_v[p] = v; t_d[p] = d; t_plv[p] = plv; t_mat[p] = mat;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        clear_inputs();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== '0 || out_paddr !== '0 || out_mat !== '0 || out_exc !== '0) begin
            errors++; $display("FAIL reset_outputs: valid=%b paddr=%h mat=%h exc=%h required all zero", out_valid, out_paddr, out_mat, out_exc); end
        rstn = 1'b1;
        #1;
        checks++; if (miss_cnt !== '0) begin errors++; $display("FAIL reset_miss: got %h required 0", miss_cnt); end
        checks++; if (in_ready !== 2'b11) begin errors++; $display("FAIL reset_in_ready: got %b required 11", in_ready); end
        tick();
    endtask

    task automatic test_saturation();
        clear_inputs();
        ad_mode = 2'b10;
        t_found[0] = 1'b0;
        in_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (out_valid[0] !== 1'b1 || out_exc[2:0] !== 3'd1) begin
                errors++; $display("FAIL sat_b2b_%0d: valid=%b exc=%0d required valid=1 exc=1", i, out_valid[0], out_exc[2:0]); end
        end
        in_valid = '0;
        checks++; if (o2_miss !== 2'd3) begin errors++; $display("FAIL sat_cntw2: got %0d required 3", o2_miss); end
        checks++; if (miss_cnt[15:0] !== 16'd5) begin errors++; $display("FAIL sat_cnt16: got %0d required 5", miss_cnt[15:0]); end
        tick();
    endtask

    task automatic test_direct();
        clear_inputs();
        t_vaddr[0] = 32'h1234_5678;
        in_valid[0] = 1'b1;
        tick();
        in_valid = '0;
        checks++; if (out_valid[0] !== 1'b1 || out_paddr[31:0] !== 32'h1234_5678 || out_mat[1:0] !== 2'd0 || out_exc[2:0] !== 3'd0) begin
            errors++; $display("FAIL direct: valid=%b paddr=%h mat=%0d exc=%0d required 1/12345678/0/0", out_valid[0], out_paddr[31:0], out_mat[1:0], out_exc[2:0]); end
        tick();
    endtask

    task automatic test_map_4k();
        clear_inputs();
        ad_mode = 2'b10;
        set_tlb(1, 32'h0000_0F0C, 2'd1, 20'hABCDE, 6'd12, 1'b1, 1'b1, 2'd3, 2'd1);
        in_valid[1] = 1'b1;
        tick();
        in_valid = '0;
        checks++; if (out_valid[1] !== 1'b1 || out_paddr[63:32] !== 32'hABCD_EF0C || out_exc[5:3] !== 3'd0 || out_mat[3:2] !== 2'd1) begin
            errors++; $display("FAIL map_4k: valid=%b paddr=%h exc=%0d mat=%0d required 1/ABCDEF0C/0/1", out_valid[1], out_paddr[63:32], out_exc[5:3], out_mat[3:2]); end
        tick();
    endtask

    task automatic test_map_4m();
        int base;
        clear_inputs();
        ad_mode = 2'b10;
        set_tlb(0, 32'h003F_FFFC, 2'd1, 20'h00300, 6'd22, 1'b1, 1'b1, 2'd3, 2'd2);
        in_valid[0] = 1'b1;
        tick();
        checks++; if (out_paddr[31:0] !== 32'h003F_FFFC || out_exc[2:0] !== 3'd0) begin
            errors++; $display("FAIL map_4m: paddr=%h exc=%0d required 003FFFFC/0", out_paddr[31:0], out_exc[2:0]); end
        base = m_miss[0];
        t_ps[0] = 6'd13;
        tick();
        in_valid = '0;
        checks++; if (out_exc[2:0] !== 3'd1 || out_paddr[31:0] !== 32'h0) begin
            errors++; $display("FAIL bad_ps: exc=%0d paddr=%h required 1/0", out_exc[2:0], out_paddr[31:0]); end
        checks++; if (miss_cnt[15:0] !== 16'(base + 1)) begin
            errors++; $display("FAIL bad_ps_cnt: got %0d required %0d", miss_cnt[15:0], base + 1); end
        tick();
    endtask

    task automatic test_exceptions();
        logic [1:0] acc_t  [5] = '{2'd2, 2'd2, 2'd0, 2'd1, 2'd1};
        logic       v_t    [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic       d_t    [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [1:0] tplv_t [5] = '{2'd3, 2'd3, 2'd3, 2'd0, 2'd3};
        logic [1:0] cplv_t [5] = '{2'd0, 2'd0, 2'd0, 2'd3, 2'd0};
        logic [1:0] mode_t [5] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b11};
        logic [2:0] exp_t  [5] = '{3'd6, 3'd4, 3'd2, 3'd5, 3'd7};
        clear_inputs();
        for (int i = 0; i < 5; i++) begin
            int p = i % 2;
            ad_mode = mode_t[i];
            cur_plv = cplv_t[i];
            set_tlb(p, 32'h0000_1234, acc_t[i], 20'h12345, 6'd12, v_t[i], d_t[i], tplv_t[i], 2'd1);
            in_valid = '0;
            in_valid[p] = 1'b1;
            tick();
            checks++; if (out_valid[p] !== 1'b1 || out_exc[p*3 +: 3] !== exp_t[i] || out_paddr[p*PA +: PA] !== '0 || out_mat[p*2 +: 2] !== 2'd0) begin
                errors++; $display("FAIL exc_case_%0d: valid=%b exc=%0d paddr=%h mat=%0d required exc=%0d paddr=0 mat=0",
                                   i, out_valid[p], out_exc[p*3 +: 3], out_paddr[p*PA +: PA], out_mat[p*2 +: 2], exp_t[i]); end
        end
        in_valid = '0;
        tick();
    endtask

    task automatic test_back_to_back_hold();
        int base;
        clear_inputs();
        out_ready[0] = 1'b0;
        t_vaddr[0] = 32'hAAAA_0001;
        in_valid[0] = 1'b1;
        tick();
        checks++; if (out_valid[0] !== 1'b1 || out_paddr[31:0] !== 32'hAAAA_0001) begin
            errors++; $display("FAIL hold_first: valid=%b paddr=%h required 1/AAAA0001", out_valid[0], out_paddr[31:0]); end
        base = m_miss[0];
        t_vaddr[0] = 32'hBBBB_0002;
        ad_mode = 2'b10;
        t_found[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready[0] !== 1'b0) begin errors++; $display("FAIL hold_in_ready_%0d: got %b required 0", i, in_ready[0]); end
            tick();
            checks++; if (out_valid[0] !== 1'b1 || out_paddr[31:0] !== 32'hAAAA_0001 || out_exc[2:0] !== 3'd0 || miss_cnt[15:0] !== 16'(base)) begin
                errors++; $display("FAIL hold_stable_%0d: valid=%b paddr=%h exc=%0d miss=%0d required 1/AAAA0001/0/%0d",
                                   i, out_valid[0], out_paddr[31:0], out_exc[2:0], miss_cnt[15:0], base); end
        end
        ad_mode = 2'b01;
        out_ready[0] = 1'b1;
        #1;
        checks++; if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b required 1", in_ready[0]); end
        tick();
        in_valid = '0;
        checks++; if (out_valid[0] !== 1'b1 || out_paddr[31:0] !== 32'hBBBB_0002) begin
            errors++; $display("FAIL release_accept: valid=%b paddr=%h required 1/BBBB0002", out_valid[0], out_paddr[31:0]); end
        tick();
        checks++; if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL drain: valid=%b required 0", out_valid[0]); end
    endtask

    task automatic test_flush();
        int base;
        clear_inputs();
        out_ready[0] = 1'b0;
        t_vaddr[0] = 32'hCAFE_0000;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        base = m_miss[1];
        ad_mode = 2'b10;
        t_found[1] = 1'b0;
        in_valid[1] = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL flush_valid: got %b required 00", out_valid); end
        checks++; if (miss_cnt[31:16] !== 16'(base)) begin errors++; $display("FAIL flush_cnt: got %0d required %0d", miss_cnt[31:16], base); end
        tick();
        in_valid = '0;
        checks++; if (out_valid[1] !== 1'b1 || out_exc[5:3] !== 3'd1 || miss_cnt[31:16] !== 16'(base + 1)) begin
            errors++; $display("FAIL post_flush: valid=%b exc=%0d miss=%0d required 1/1/%0d", out_valid[1], out_exc[5:3], miss_cnt[31:16], base + 1); end
        out_ready = '1;
        tick();
    endtask

    task automatic test_random();
        clear_inputs();
        for (int n = 0; n < 600; n++) begin
            int r = $urandom_range(0, 15);
            ad_mode = (r < 12) ? 2'b10 : (r < 14) ? 2'b01 : (r == 14) ? 2'b00 : 2'b11;
            cur_plv = 2'($urandom);
            flush   = ($urandom_range(0, 19) == 0);
            for (int p = 0; p < NP; p++) begin
                int s = $urandom_range(0, 3);
                in_valid[p]  = ($urandom_range(0, 3) != 0);
                out_ready[p] = ($urandom_range(0, 3) != 0);
                t_vaddr[p] = $urandom; t_acc[p] = 2'($urandom); t_dmw_hit[p] = ($urandom_range(0, 3) == 0);
                t_dmw_paddr[p] = $urandom; t_dmw_mat[p] = 2'($urandom); t_found[p] = ($urandom_range(0, 7) != 0);
                t_pfn[p] = PFNW'($urandom); t_ps[p] = (s < 2) ? 6'd12 : (s == 2) ? 6'd22 : 6'($urandom);
                t_mat[p] = 2'($urandom); t_v[p] = ($urandom_range(0, 7) != 0); t_d[p] = ($urandom_range(0, 3) != 0);
                t_plv[p] = 2'($urandom);
            end
            #1;
            for (int p = 0; p < NP; p++) begin
                checks++; if (in_ready[p] !== (!m_valid[p] || out_ready[p])) begin
                    errors++; $display("FAIL rnd_in_ready n=%0d p=%0d: got %b required %b", n, p, in_ready[p], !m_valid[p] || out_ready[p]); end
            end
            tick();
            for (int p = 0; p < NP; p++) begin
                checks++; if (out_valid[p] !== m_valid[p]) begin
                    errors++; $display("FAIL rnd_valid n=%0d p=%0d: got %b required %b", n, p, out_valid[p], m_valid[p]); end
                if (m_valid[p]) begin
                    checks++; if (out_paddr[p*PA +: PA] !== m_paddr[p] || out_mat[p*2 +: 2] !== m_mat[p] || out_exc[p*3 +: 3] !== m_exc[p]) begin
                        errors++; $display("FAIL rnd_data n=%0d p=%0d: paddr=%h mat=%0d exc=%0d required %h/%0d/%0d", n, p,
                                           out_paddr[p*PA +: PA], out_mat[p*2 +: 2], out_exc[p*3 +: 3], m_paddr[p], m_mat[p], m_exc[p]); end
                end
                checks++; if (miss_cnt[p*CW +: CW] !== CW'(m_miss[p])) begin
                    errors++; $display("FAIL rnd_miss n=%0d p=%0d: got %0d required %0d", n, p, miss_cnt[p*CW +: CW], m_miss[p]); end
            end
            checks++; if (o2_miss !== 2'(m_miss2)) begin
                errors++; $display("FAIL rnd_miss_sat n=%0d: got %0d required %0d", n, o2_miss, m_miss2); end
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_async_reset();
        clear_inputs();
        out_ready = '0;
        t_vaddr[0] = 32'h5555_AAAA;
        t_vaddr[1] = 32'h0F0F_0F0F;
        in_valid = 2'b11;
        tick();
        checks++; if (out_valid !== 2'b11) begin errors++; $display("FAIL pre_reset_valid: got %b required 11", out_valid); end
        #2;
        rstn = 1'b0;
        #1;
        checks++; if (out_valid !== '0 || out_paddr !== '0 || out_mat !== '0 || out_exc !== '0 || miss_cnt !== '0 || o2_miss !== '0) begin
            errors++; $display("FAIL async_reset: valid=%b paddr=%h mat=%h exc=%h miss=%h sat=%0d required all zero",
                               out_valid, out_paddr, out_mat, out_exc, miss_cnt, o2_miss); end
        in_valid = '0;
        tick();
        rstn = 1'b1;
        #1;
        checks++; if (in_ready !== 2'b11) begin errors++; $display("FAIL post_reset_ready: got %b required 11", in_ready); end
        tick();
    endtask

    initial begin
        test_reset();
        test_saturation();
        test_direct();
        test_map_4k();
        test_map_4m();
        test_exceptions();
        test_back_to_back_hold();
        test_flush();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
